// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: button-triggered program-load sequencer driving loader/CPU resets and memory write routing.
// Optional load watchdog compiled in with BOOT_WATCHDOG_EN.
module boot_load_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int RELEASE_DELAY   = 16,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start_pg,
    input  logic        upg_done_i,
    input  logic        upg_wen_i,
    input  logic [14:0] upg_adr_i,
    output logic        upg_rst_o,
    output logic        cpu_rst_o,
    output logic        rom_wen_o,
    output logic        dmem_wen_o,
    output logic [1:0]  mode_o,
    output logic [15:0] words_loaded_o,
    output logic        err_o
);
    typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1, DRAIN = 2'd2} state_t;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int RW = $clog2(RELEASE_DELAY + 1);
    state_t state, state_d;
    logic sync0, sync1, press, timeout, unused_bits;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] dly;
    assign unused_bits = ^{upg_adr_i[13:0], TIMEOUT_CYCLES == 0};
    always_ff @(posedge clock) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= start_pg;
            sync1 <= sync0;
        end
    end
    // Counter parks one past the threshold so a held button fires only once.
    always_ff @(posedge clock) begin
        if (rst || !sync1)
            db_cnt <= '0;
        else if (db_cnt != DW'(DEBOUNCE_CYCLES + 1))
            db_cnt <= db_cnt + 1'b1;
    end
    assign press = db_cnt == DW'(DEBOUNCE_CYCLES);
`ifdef BOOT_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd;
    always_ff @(posedge clock) begin
        if (rst || state != LOAD || upg_wen_i)
            wd <= '0;
        else if (!timeout)
            wd <= wd + 1'b1;
    end
    assign timeout = state == LOAD && !upg_wen_i && !upg_done_i && wd == TW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d = state;
        case (state)
            RUN:     state_d = press ? LOAD : RUN;
            LOAD:    state_d = (upg_done_i || timeout) ? DRAIN : LOAD;
            DRAIN:   state_d = (dly == RW'(RELEASE_DELAY - 1)) ? RUN : DRAIN;
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge clock) begin
        if (rst) begin
            state          <= RUN;
            cpu_rst_o      <= 1'b1;
            dly            <= '0;
            words_loaded_o <= '0;
            err_o          <= 1'b0;
        end else begin
            state     <= state_d;
            cpu_rst_o <= state_d != RUN;
            dly       <= (state == DRAIN) ? dly + 1'b1 : '0;
            if (state == RUN && press)
                words_loaded_o <= '0;
            else if (state == LOAD && upg_wen_i && words_loaded_o != 16'hFFFF)
                words_loaded_o <= words_loaded_o + 1'b1;
            if (state == RUN && press)
                err_o <= 1'b0;
            else if (timeout)
                err_o <= 1'b1;
        end
    end
    assign mode_o     = state;
    assign upg_rst_o  = state != LOAD;
    assign rom_wen_o  = state == LOAD && upg_wen_i && !upg_adr_i[14];
    assign dmem_wen_o = state == LOAD && upg_wen_i && upg_adr_i[14];
endmodule

// File: tb/tb_boot_load_ctrl.sv
// tb_boot_load_ctrl: directed vector bench for boot_load_ctrl (DEBOUNCE 4, RELEASE 3, TIMEOUT 20).
module tb_boot_load_ctrl;
    logic clock = 1'b0;
    logic rst, start_pg, upg_done_i, upg_wen_i;
    logic [14:0] upg_adr_i;
    logic upg_rst_o, cpu_rst_o, rom_wen_o, dmem_wen_o, err_o;
    logic [1:0] mode_o;
    logic [15:0] words_loaded_o;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic        wen;
        logic [14:0] adr;
        logic        done;
        logic        rom;
        logic        dmem;
        logic [1:0]  mode;
        logic        cpu;
        logic        upg;
        logic [15:0] words;
    } vec_t;
    vec_t tv[12];

    boot_load_ctrl #(.DEBOUNCE_CYCLES(4), .RELEASE_DELAY(3), .TIMEOUT_CYCLES(20)) dut (
        .clock(clock), .rst(rst), .start_pg(start_pg), .upg_done_i(upg_done_i),
        .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_rst_o(upg_rst_o),
        .cpu_rst_o(cpu_rst_o), .rom_wen_o(rom_wen_o), .dmem_wen_o(dmem_wen_o),
        .mode_o(mode_o), .words_loaded_o(words_loaded_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_press(input logic hold);
        start_pg = 1'b0;
        repeat (4) tick();
        start_pg = 1'b1;
        repeat (6) tick();
        chk("press_early_mode", {30'd0, mode_o}, 0);
        tick();
        chk("press_mode", {30'd0, mode_o}, 1);
        chk("press_cpu_rst", {31'd0, cpu_rst_o}, 1);
        chk("press_upg_rst", {31'd0, upg_rst_o}, 0);
        chk("press_words", {16'd0, words_loaded_o}, 0);
        chk("press_err", {31'd0, err_o}, 0);
        start_pg = hold;
    endtask

    initial begin
        rst = 1'b1; start_pg = 1'b0; upg_done_i = 1'b0; upg_wen_i = 1'b0; upg_adr_i = '0;
        tv[0]  = '{1'b1, 15'h0000, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 16'd0};
        tv[1]  = '{1'b1, 15'h0001, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 16'd1};
        tv[2]  = '{1'b1, 15'h4000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 16'd2};
        tv[3]  = '{1'b1, 15'h4002, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 16'd3};
        tv[4]  = '{1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'd4};
        tv[5]  = '{1'b1, 15'h0010, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 16'd4};
        tv[6]  = '{1'b1, 15'h4000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 16'd5};
        tv[7]  = '{1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 16'd5};
        tv[8]  = '{1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 16'd5};
        tv[9]  = '{1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'd5};
        tv[10] = '{1'b1, 15'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'd5};
        tv[11] = '{1'b0, 15'h4000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'd5};

        // reset and idle
        tick(); tick();
        chk("rst_mode", {30'd0, mode_o}, 0);
        chk("rst_upg_rst", {31'd0, upg_rst_o}, 1);
        chk("rst_cpu_rst", {31'd0, cpu_rst_o}, 1);
        chk("rst_rom_wen", {31'd0, rom_wen_o}, 0);
        chk("rst_dmem_wen", {31'd0, dmem_wen_o}, 0);
        chk("rst_words", {16'd0, words_loaded_o}, 0);
        chk("rst_err", {31'd0, err_o}, 0);
        rst = 1'b0;
        #2 chk("cpu_rst_hold", {31'd0, cpu_rst_o}, 1);
        tick();
        chk("cpu_rst_release", {31'd0, cpu_rst_o}, 0);
        chk("idle_upg_rst", {31'd0, upg_rst_o}, 1);

        // bounce rejection
        for (int p = 0; p < 4; p++) begin
            start_pg = (p % 2 == 0);
            repeat (3) begin
                tick();
                chk("bounce_mode", {30'd0, mode_o}, 0);
            end
        end

        // press held through the whole load and release
        do_press(1'b1);
        for (int i = 0; i < 12; i++) begin
            upg_wen_i = tv[i].wen; upg_adr_i = tv[i].adr; upg_done_i = tv[i].done;
            #2;
            chk("vec_rom_wen", {31'd0, rom_wen_o}, {31'd0, tv[i].rom});
            chk("vec_dmem_wen", {31'd0, dmem_wen_o}, {31'd0, tv[i].dmem});
            chk("vec_mode", {30'd0, mode_o}, {30'd0, tv[i].mode});
            chk("vec_cpu_rst", {31'd0, cpu_rst_o}, {31'd0, tv[i].cpu});
            chk("vec_upg_rst", {31'd0, upg_rst_o}, {31'd0, tv[i].upg});
            chk("vec_words", {16'd0, words_loaded_o}, {16'd0, tv[i].words});
            tick();
        end
        upg_wen_i = 1'b0; upg_done_i = 1'b0; upg_adr_i = '0;
        chk("held_no_reentry", {30'd0, mode_o}, 0);

        // reset mid-load
        do_press(1'b0);
        upg_wen_i = 1'b1;
        tick(); tick();
        upg_wen_i = 1'b0;
        chk("midload_words", {16'd0, words_loaded_o}, 2);
        rst = 1'b1; upg_wen_i = 1'b1; upg_adr_i = 15'h4000;
        tick();
        chk("midrst_mode", {30'd0, mode_o}, 0);
        chk("midrst_words", {16'd0, words_loaded_o}, 0);
        chk("midrst_upg_rst", {31'd0, upg_rst_o}, 1);
        chk("midrst_cpu_rst", {31'd0, cpu_rst_o}, 1);
        chk("midrst_rom_wen", {31'd0, rom_wen_o}, 0);
        chk("midrst_dmem_wen", {31'd0, dmem_wen_o}, 0);
        rst = 1'b0; upg_wen_i = 1'b0; upg_adr_i = '0;
        tick();
        chk("postrst_cpu_rst", {31'd0, cpu_rst_o}, 0);

        // silent load: watchdog timeout or indefinite wait
        do_press(1'b0);
        repeat (19) tick();
        chk("wd_before_mode", {30'd0, mode_o}, 1);
        tick();
`ifdef BOOT_WATCHDOG_EN
        chk("wd_mode", {30'd0, mode_o}, 2);
        chk("wd_err", {31'd0, err_o}, 1);
        repeat (3) tick();
        chk("wd_run_mode", {30'd0, mode_o}, 0);
        chk("wd_err_sticky", {31'd0, err_o}, 1);
        do_press(1'b0);
`else
        chk("nowd_mode", {30'd0, mode_o}, 1);
        chk("nowd_err", {31'd0, err_o}, 0);
        repeat (10) tick();
        chk("nowd_wait_mode", {30'd0, mode_o}, 1);
`endif
        upg_done_i = 1'b1;
        tick();
        chk("done_drain_mode", {30'd0, mode_o}, 2);
        upg_done_i = 1'b0;
        repeat (3) tick();
        chk("done_run_mode", {30'd0, mode_o}, 0);
        chk("done_run_cpu", {31'd0, cpu_rst_o}, 0);

        // done already high on entry to LOAD
        upg_done_i = 1'b1;
        do_press(1'b0);
        tick();
        chk("early_done_mode", {30'd0, mode_o}, 2);
        chk("early_done_words", {16'd0, words_loaded_o}, 0);
        upg_done_i = 1'b0;
        repeat (3) tick();
        chk("early_done_run", {30'd0, mode_o}, 0);
        chk("final_err", {31'd0, err_o}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
